uart_tx_sched: RTL and testbench

- Sits between the CPU's MMIO write port (UART line of the I/O decoder) and the UART transmitter.
- Buffers bytes written by the core in a FIFO and drains them one at a time into the transmitter using a start/busy handshake.
- The core never stalls. Status (full, level, overflow) is readable by the top level for an MMIO status register.

---
 rtl/uart_tx_sched.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: FIFO-buffers MMIO byte writes and drains them
// into a UART transmitter with a start/busy handshake and ack timeout.
//
// Parameters:
//   DEPTH_LOG2  - FIFO depth is 2**DEPTH_LOG2 entries
//   ACK_TIMEOUT - cycles to wait for tx_busy_i after tx_start_o (1..255)
// Ports:
//   clk_i, rst_ni       - clock, synchronous active-low reset
//   wr_en_i, wr_data_i  - MMIO byte write strobe and data
//   clr_ovf_i           - clears the sticky overflow flag
//   tx_busy_i           - transmitter busy (start .. stop bit)
//   tx_start_o          - one-cycle start pulse to the transmitter
//   tx_data_o           - byte presented to the transmitter
//   full_o, empty_o     - registered FIFO full / empty
//   level_o             - registered FIFO occupancy
//   overflow_o          - sticky: a write was dropped
//   timeout_o           - sticky: transmitter never acknowledged a start
// Build option:
//   UART_TX_SCHED_CRLF_EN - expand each popped LF (0x0A) into CR, LF
module uart_tx_sched #(
    parameter int DEPTH_LOG2  = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  clr_ovf_i,
    input  logic                  tx_busy_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    output logic                  timeout_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [7:0]            TMO_INIT = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        ACK,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;
    logic [7:0]            data_q, data_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  pop;
    logic                  push;
    logic                  drop;
`ifdef UART_TX_SCHED_CRLF_EN
    logic                  lf_q, lf_d;
`endif

    // FSM: pops from the head only in IDLE, using the registered empty
    // flag so a fresh write is seen one cycle later.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
        lf_d    = lf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty_q && !tx_busy_i) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = START;
`ifdef UART_TX_SCHED_CRLF_EN
                    if (mem_q[rd_ptr_q] == 8'h0A) begin
                        data_d = 8'h0D;
                        lf_d   = 1'b1;
                    end
`endif
                end
            end
            START: begin
                cnt_d   = TMO_INIT;
                state_d = ACK;
            end
            ACK: begin
                if (tx_busy_i) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    // counter reaching zero: give up on this byte
                    if (cnt_q == 8'd1) begin
                        tmo_d   = 1'b1;
                        state_d = IDLE;
`ifdef UART_TX_SCHED_CRLF_EN
                        lf_d    = 1'b0;
`endif
                    end
                end
            end
            DONE: begin
                if (!tx_busy_i) begin
                    state_d = IDLE;
`ifdef UART_TX_SCHED_CRLF_EN
                    // CR finished: send the held LF without a new pop
                    if (lf_q) begin
                        data_d  = 8'h0A;
                        lf_d    = 1'b0;
                        state_d = START;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a pop frees the slot a same-cycle push needs
    always_comb begin
        push     = wr_en_i && (!full_q || pop);
        drop     = wr_en_i && full_q && !pop;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LVL_ONE;
        if (pop && !push) level_d = level_q - LVL_ONE;
        full_d   = (level_d == LVL_FULL);
        empty_d  = (level_d == '0);
        ovf_d    = ovf_q;
        if (clr_ovf_i) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            data_q   <= 8'h00;
            cnt_q    <= 8'h00;
`ifdef UART_TX_SCHED_CRLF_EN
            lf_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
`ifdef UART_TX_SCHED_CRLF_EN
            lf_q     <= lf_d;
`endif
        end
    end

    assign tx_start_o = (state_q == START);
    assign tx_data_o  = data_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: accepted writes queue expected
// bytes, a monitor pops and compares on every tx_start pulse.
module tb_uart_tx_sched;

    localparam int DL    = 3;
    localparam int TMO   = 15;
    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_ovf;
    logic        tx_busy;
    logic        busy_model;
    logic        busy_force;
    logic        ack_en;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        full;
    logic        empty;
    logic [DL:0] level;
    logic        overflow;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0;
    int last_start_cyc = 0;
    logic [7:0] exp_q [$];

    assign tx_busy = busy_model | busy_force;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(
        .DEPTH_LOG2 (DL),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .clr_ovf_i (clr_ovf),
        .tx_busy_i (tx_busy),
        .tx_start_o(tx_start),
        .tx_data_o (tx_data),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level),
        .overflow_o(overflow),
        .timeout_o (timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // transmitter: busy rises one cycle after start, lasts FRAME cycles
    always begin
        @(negedge clk);
        if (tx_start && ack_en) begin
            @(negedge clk);
            busy_model = 1'b1;
            repeat (FRAME) @(negedge clk);
            busy_model = 1'b0;
        end
    end

    // monitor
    always @(negedge clk) begin
        if (tx_start) begin
            n_start++;
            last_start_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start actual=%0h required=none",
                         tx_data);
            end else begin
                chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic wr(input logic [7:0] b, input bit acc);
        wr_en   = 1'b1;
        wr_data = b;
        if (acc) begin
`ifdef UART_TX_SCHED_CRLF_EN
            if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(b);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int q = 0;
        int n = 0;
        while (q < 5 && n < 3000) begin
            @(negedge clk);
            n++;
            if (empty && !tx_busy) q++;
            else q = 0;
        end
        chk(nm, {31'b0, q == 5}, 1);
    endtask

    initial begin
        int s;
        int wcyc;
        int n;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        clr_ovf    = 1'b0;
        busy_model = 1'b0;
        busy_force = 1'b0;
        ack_en     = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state and quiet idle
        chk("rst_empty", {31'b0, empty}, 1);
        chk("rst_level", {28'b0, level}, 0);
        chk("rst_txdata", {24'b0, tx_data}, 0);
        chk("rst_full", {31'b0, full}, 0);
        chk("rst_ovf", {31'b0, overflow}, 0);
        chk("rst_tmo", {31'b0, timeout}, 0);
        repeat (20) @(negedge clk);
        chk("idle_nostart", n_start, 0);

        // single byte latency
        s    = n_start;
        wcyc = cyc;
        wr(8'h41, 1'b1);
        chk("t2_level1", {28'b0, level}, 1);
        chk("t2_empty0", {31'b0, empty}, 0);
        @(negedge clk);
        chk("t2_level0", {28'b0, level}, 0);
        wait_idle("t2_idle");
        chk("t2_latency", last_start_cyc - wcyc, 2);
        chk("t2_pulses", n_start - s, 1);

        // burst to full, overflow, clear
        for (int i = 0; i < 9; i++) wr(8'h30 + 8'(i), 1'b1);
        chk("t3_level8", {28'b0, level}, 8);
        chk("t3_full", {31'b0, full}, 1);
        wr(8'h39, 1'b0);
        chk("t3_ovf", {31'b0, overflow}, 1);
        clr_ovf = 1'b1;
        wr(8'h3A, 1'b0);
        clr_ovf = 1'b0;
        chk("t3_set_wins", {31'b0, overflow}, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("t3_clr", {31'b0, overflow}, 0);
        wait_idle("t3_idle");

        // full + push on the pop cycle, pointers wrapped
        busy_force = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 1'b1);
        chk("t4_level8", {28'b0, level}, 8);
        busy_force = 1'b0;
        wr(8'h88, 1'b1);
        chk("t4_level_kept", {28'b0, level}, 8);
        chk("t4_full", {31'b0, full}, 1);
        chk("t4_no_ovf", {31'b0, overflow}, 0);
        wait_idle("t4_idle");

        // ack timeout
        ack_en = 1'b0;
        wr(8'h55, 1'b1);
        n = 0;
        while (!timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_tmo_cycles", n, TMO + 2);
        ack_en = 1'b1;
        wr(8'h66, 1'b1);
        wait_idle("t5_idle");
        chk("t5_tmo_sticky", {31'b0, timeout}, 1);

        // reset during DONE with 3 bytes queued
        for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i), 1'b1);
        n = 0;
        while (!busy_model && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("t6_level3", {28'b0, level}, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        chk("t6_level0", {28'b0, level}, 0);
        chk("t6_empty", {31'b0, empty}, 1);
        chk("t6_txdata", {24'b0, tx_data}, 0);
        chk("t6_tmo_clr", {31'b0, timeout}, 0);
        s = n_start;
        repeat (60) @(negedge clk);
        chk("t6_nostart", n_start - s, 0);

        // line feed handling (CR inserted when enabled)
        s = n_start;
        wr(8'h0A, 1'b1);
        wr(8'h42, 1'b1);
        wait_idle("t7_idle");
`ifdef UART_TX_SCHED_CRLF_EN
        chk("t7_pulses", n_start - s, 3);
`else
        chk("t7_pulses", n_start - s, 2);
`endif
        chk("t7_level", {28'b0, level}, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
